// File: rtl/ucie_ctl_tx_fifo.sv
// ucie_ctl_tx_fifo: FWFT TX data buffer between FDI and RDI with soft flush and debug pulses
module ucie_ctl_tx_fifo #(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  winc,
  input  logic                  wrst_n,
  input  logic                  rinc,
  input  logic                  rrst_n,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  o_awfull,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_ovf_drop,
  output logic                  o_udf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF = AFULL_THRESH[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wptr, rptr;
  logic we, re, flush;
  assign flush = ~wrst_n | ~rrst_n;
  assign rempty = wptr == rptr;
  assign wfull = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign o_level = wptr - rptr;
  assign o_awfull = o_level >= AF;
  assign we = winc & ~wfull;
  assign re = rinc & ~rempty;
  assign o_rdata = mem[rptr[ADDR_WIDTH-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      o_ovf_drop <= 1'b0;
      o_udf <= 1'b0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      o_ovf_drop <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      wptr <= wptr + (ADDR_WIDTH+1)'(we);
      rptr <= rptr + (ADDR_WIDTH+1)'(re);
      o_ovf_drop <= winc & wfull;
      o_udf <= rinc & rempty;
    end
  end
  // storage is not reset; flush suppresses the write so nothing lands behind the cleared pointers
  always_ff @(posedge clk) begin
    if (we && !flush) mem[wptr[ADDR_WIDTH-1:0]] <= i_wdata;
  end
endmodule

// File: tb/tb_ucie_ctl_tx_fifo.sv
// tb_ucie_ctl_tx_fifo: directed stimulus against a queue-based model of the TX FIFO
module tb_ucie_ctl_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [511:0] i_wdata = '0;
  logic winc = 1'b0, rinc = 1'b0, wrst_n = 1'b1, rrst_n = 1'b1;
  logic [511:0] o_rdata;
  logic wfull, rempty, o_awfull, o_ovf_drop, o_udf;
  logic [3:0] o_level;
  int checks = 0;
  int errors = 0;
  logic [511:0] q[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;

  ucie_ctl_tx_fifo #(.DATA_WIDTH(512), .ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .clk(clk), .rst(rst), .i_wdata(i_wdata), .winc(winc), .wrst_n(wrst_n),
    .rinc(rinc), .rrst_n(rrst_n), .o_rdata(o_rdata), .wfull(wfull), .rempty(rempty),
    .o_awfull(o_awfull), .o_level(o_level), .o_ovf_drop(o_ovf_drop), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: a queue of at most 8 entries; full/empty judged before the edge
  always @(posedge clk or posedge rst) begin
    if (rst || !wrst_n || !rrst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit full = q.size() == 8;
      automatic bit empty = q.size() == 0;
      m_ovf = winc && full;
      m_udf = rinc && empty;
      if (rinc && !empty) void'(q.pop_front());
      if (winc && !full) q.push_back(i_wdata);
    end
  end

  always @(negedge clk) begin
    chk("m_level", 512'(o_level), 512'(q.size()));
    chk("m_empty", 512'(rempty), 512'(q.size() == 0));
    chk("m_full", 512'(wfull), 512'(q.size() == 8));
    chk("m_awfull", 512'(o_awfull), 512'(q.size() >= 6));
    chk("m_ovf", 512'(o_ovf_drop), 512'(m_ovf));
    chk("m_udf", 512'(o_udf), 512'(m_udf));
    if (q.size() != 0) chk("m_rdata", o_rdata, q[0]);
  end

  task automatic step(input logic w, input logic [511:0] d, input logic r);
    winc = w;
    i_wdata = d;
    rinc = r;
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty", 512'(rempty), 512'(1));
    chk("rst_level", 512'(o_level), 512'(0));
    chk("rst_full", 512'(wfull), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 512'(i), 1'b0);
      chk("fill_level", 512'(o_level), 512'(i));
      chk("fill_awfull", 512'(o_awfull), 512'(i >= 6));
      chk("fill_rdata", o_rdata, 512'(1));
    end
    chk("fill_full", 512'(wfull), 512'(1));
    step(1'b1, 512'hAA, 1'b0);
    chk("ovf_pulse", 512'(o_ovf_drop), 512'(1));
    chk("ovf_level", 512'(o_level), 512'(8));
    step(1'b0, '0, 1'b0);
    chk("ovf_clear", 512'(o_ovf_drop), 512'(0));
    for (int i = 1; i <= 8; i++) begin
      chk("drain_rdata", o_rdata, 512'(i));
      step(1'b0, '0, 1'b1);
    end
    chk("drain_empty", 512'(rempty), 512'(1));
    for (int i = 1; i <= 8; i++) step(1'b1, 512'(i), 1'b0);
    step(1'b1, 512'hBB, 1'b1);
    chk("fullrw_level", 512'(o_level), 512'(7));
    chk("fullrw_ovf", 512'(o_ovf_drop), 512'(1));
    chk("fullrw_rdata", o_rdata, 512'(2));
    rrst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    rrst_n = 1'b1;
    chk("rflush_level", 512'(o_level), 512'(0));
    step(1'b1, 512'h55, 1'b1);
    chk("emptyrw_udf", 512'(o_udf), 512'(1));
    chk("emptyrw_level", 512'(o_level), 512'(1));
    chk("emptyrw_rdata", o_rdata, 512'h55);
    for (int i = 0; i < 20; i++) begin
      chk("stream_rdata", o_rdata, (i == 0) ? 512'h55 : 512'(32'h100 + i - 1));
      step(1'b1, 512'(32'h100 + i), 1'b1);
      chk("stream_level", 512'(o_level), 512'(1));
    end
    chk("stream_tail", o_rdata, 512'h113);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 512'(32'h10 + i), 1'b0);
    chk("hold4_level", 512'(o_level), 512'(4));
    wrst_n = 1'b0;
    step(1'b1, 512'hEE, 1'b0);
    wrst_n = 1'b1;
    chk("wflush_empty", 512'(rempty), 512'(1));
    chk("wflush_level", 512'(o_level), 512'(0));
    step(1'b1, 512'h77, 1'b0);
    chk("postflush_rdata", o_rdata, 512'h77);
    for (int i = 0; i < 3; i++) step(1'b1, 512'(32'h30 + i), 1'b0);
    chk("pre_arst_level", 512'(o_level), 512'(4));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", 512'(rempty), 512'(1));
    chk("arst_level", 512'(o_level), 512'(0));
    chk("arst_full", 512'(wfull), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
